instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Consumer side of the program counter in the multicycle RISC-V core. On a fetch request from the control FSM it reads the current PC and issues a word read to instruction memory over a req/ack bus. It captures the returned instruction and the PC it came from, then pulses the PC write-enable so the counter advances. Misaligned PCs and unresponsive memory are reported as a fetch fault instead of hanging the core.

Parameters:
RESET_PC, 32'h00001000, boot address; reset value of old_pc.
TIMEOUT_CYCLES, 16, REQ-state cycles without mem_ack before a fault is raised (range 2..255).

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  synchronous, active-high
fetch_start  input  1  control FSM requests a fetch (level; sampled only in IDLE)
pc  input  32  current program counter
mem_req  output  1  read request to instruction memory, held until acked
mem_addr  output  32  word address for read; stable while mem_req=1
mem_ack  input  1  memory has valid mem_rdata this cycle
mem_rdata  input  32  instruction word
instr  output  32  instruction register
old_pc  output  32  PC of the instruction held in instr
pc_plus4  output  32  old_pc + 4, combinational
fetch_done  output  1  one-cycle pulse: instr/old_pc newly valid
pc_write  output  1  one-cycle PC enable, coincident with fetch_done
fault  output  1  one-cycle pulse: misaligned PC or timeout
busy  output  1  high in any state other than IDLE

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: state=IDLE, mem_req=0, mem_addr=0, instr=32'h00000013 (NOP), old_pc=RESET_PC, fetch_done=0, pc_write=0, fault=0, busy=0, timeout count=0.
- States: IDLE, REQ, DONE, FAULT.
- IDLE behaviour:
  - fetch_start=1 and pc[1:0]==0 -> REQ; latch mem_addr<=pc and old_pc<=pc; clear timeout count.
  - fetch_start=1 and pc[1:0]!=0 -> FAULT; latch old_pc<=pc; mem_req stays 0.
  - fetch_start=0 -> stay in IDLE.
- REQ behaviour:
  - mem_req=1 and mem_addr held constant.
  - mem_ack=1 -> instr<=mem_rdata, go to DONE.
  - Otherwise increment count; when count reaches TIMEOUT_CYCLES-1 without ack -> FAULT, drop mem_req; instr unchanged.
  - Ack in the first REQ cycle is legal.
- DONE: fetch_done=1 and pc_write=1 for exactly one cycle, then IDLE.
- FAULT: fault=1 for exactly one cycle; pc_write stays 0 so the PC does not advance; then IDLE.
- Minimum latency: fetch_start sampled at cycle 0, mem_req high at cycle 1, ack at cycle 1 -> fetch_done at cycle 2. Back-to-back fetch_start gives one fetch every 3 cycles.
- fetch_start while busy=1 is ignored; it is not queued.
- mem_ack outside REQ is ignored; instr is not modified.
- pc_plus4 wraps modulo 2^32: old_pc=32'hFFFFFFFC gives 0.
- Reset asserted in any state takes priority. Next cycle is IDLE with reset values; an outstanding mem_req is dropped and a late ack is ignored.
- pc changes after the IDLE sample have no effect on the fetch in flight.
- fetch_done, pc_write and fault are registered outputs and never high in the same cycle.

Decomposition:
- Package instr_fetch_pkg holds:
  - typedef enum fetch_state_t {IDLE, REQ, DONE, FAULT}
  - NOP_INSTR = 32'h00000013
  - DEFAULT_RESET_PC = 32'h00001000
- One sub-module, fetch_timeout_counter: clear, enable, terminal-count output, width $clog2(TIMEOUT_CYCLES).

Test Plan:
- Reset then idle: hold reset 2 cycles -> instr=32'h00000013, old_pc=32'h00001000, all strobes 0, busy=0.
- Zero-wait fetch: pc=32'h00001000, fetch_start 1 cycle, mem_ack at first REQ cycle with rdata=32'h00500093 -> mem_addr=32'h00001000; fetch_done and pc_write at cycle 2; instr=32'h00500093; pc_plus4=32'h00001004.
- Wait states: ack after 5 REQ cycles -> mem_req high 5 cycles with mem_addr stable; pc toggled mid-wait has no effect; exactly one fetch_done.
- Misaligned: pc=32'h00001002 -> no mem_req, fault pulse at cycle 1, pc_write never asserted, old_pc=32'h00001002.
- Timeout: no ack for TIMEOUT_CYCLES=16 -> fault pulse, mem_req drops, instr unchanged; a later stray ack is ignored.
- Reset mid-REQ, plus wrap: reset in 3rd REQ cycle -> IDLE and reset values next cycle. Then fetch at pc=32'hFFFFFFFC -> pc_plus4=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t    : fetch FSM state encoding (IDLE, REQ, DONE, FAULT)
//   NOP_INSTR        : canonical RISC-V NOP (addi x0, x0, 0), instr reset value
//   DEFAULT_RESET_PC : default boot address, old_pc reset value
// -----------------------------------------------------------------------------
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h00000013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h00001000;

  // A PC is fetchable only if it addresses a whole 32-bit word.
  function automatic logic pc_is_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
// Counts REQ-state cycles that pass without a memory acknowledge.
// Ports:
//   clk      : core clock
//   reset    : synchronous, active-high; clears the count
//   clear    : synchronous clear, used when a new request is launched
//   enable   : advance the count by one this cycle
//   terminal : high while the count equals TIMEOUT_CYCLES-1
// -----------------------------------------------------------------------------
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  // The FSM stops enabling once terminal is seen, so the count never wraps.
  assign terminal = (count == LAST);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetches one instruction word per fetch_start request from instruction memory,
// capturing the word and the PC it came from, then pulses pc_write so the
// program counter advances. Misaligned PCs and memory that never acknowledges
// are reported with a one-cycle fault pulse and do not advance the PC.
//
// Ports:
//   clk, reset   : core clock, synchronous active-high reset
//   fetch_start  : fetch request level, sampled only while IDLE
//   pc           : current program counter, sampled with fetch_start
//   mem_req      : read request, held until acked or timed out
//   mem_addr     : word address, stable while mem_req=1
//   mem_ack      : mem_rdata valid this cycle (honoured only in REQ)
//   mem_rdata    : instruction word from memory
//   instr        : instruction register
//   old_pc       : PC of the instruction held in instr
//   pc_plus4     : old_pc + 4 (combinational, wraps modulo 2^32)
//   fetch_done   : one-cycle pulse, instr/old_pc newly valid
//   pc_write     : one-cycle PC enable, coincident with fetch_done
//   fault        : one-cycle pulse on misaligned PC or timeout
//   busy         : high in any state other than IDLE
//   dbg_state    : current FSM state, for debug and checkers
//
// Memory handshake: a read is one transaction. mem_req rises with mem_addr
// valid and both stay constant until the first cycle in which mem_ack=1; that
// cycle carries the data and ends the transaction, mem_req drops on the next
// cycle. If no ack arrives within TIMEOUT_CYCLES request cycles the request
// is withdrawn and the transaction is abandoned; a later ack is ignored.
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_start,
  input  logic [31:0]  pc,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata,
  output logic [31:0]  instr,
  output logic [31:0]  old_pc,
  output logic [31:0]  pc_plus4,
  output logic         fetch_done,
  output logic         pc_write,
  output logic         fault,
  output logic         busy,
  output fetch_state_t dbg_state
);

  fetch_state_t state;
  fetch_state_t next_state;

  logic pc_aligned;
  logic accept;      // a fetch request is taken this cycle
  logic capture;     // memory data is taken this cycle
  logic cnt_clear;
  logic cnt_enable;
  logic timeout_tc;

  assign pc_aligned = pc_is_aligned(pc);

  // ---------------------------------------------------------------------------
  // Timeout counter: cleared when a request launches, advanced for every
  // unacknowledged REQ cycle.
  // ---------------------------------------------------------------------------
  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (timeout_tc)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    capture    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;

    case (state)
      IDLE: begin
        if (fetch_start) begin
          accept = 1'b1;
          if (pc_aligned) begin
            next_state = REQ;
            cnt_clear  = 1'b1;
          end else begin
            // A misaligned PC never reaches the memory bus.
            next_state = FAULT;
          end
        end
      end

      REQ: begin
        if (mem_ack) begin
          capture    = 1'b1;
          next_state = DONE;
        end else if (timeout_tc) begin
          next_state = FAULT;
        end else begin
          cnt_enable = 1'b1;
        end
      end

      DONE:    next_state = IDLE;
      FAULT:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. The strobes and mem_req are decoded from
  // next_state so that they are registered yet aligned with the state they
  // describe; being one-hot decodes of a single state they can never overlap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      instr      <= NOP_INSTR;
      old_pc     <= RESET_PC;
      fetch_done <= 1'b0;
      pc_write   <= 1'b0;
      fault      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= next_state;
      mem_req    <= (next_state == REQ);
      fetch_done <= (next_state == DONE);
      pc_write   <= (next_state == DONE);
      fault      <= (next_state == FAULT);
      busy       <= (next_state != IDLE);

      // pc is only looked at here, so later pc changes cannot disturb the
      // transaction in flight.
      if (accept) begin
        old_pc <= pc;
        if (pc_aligned) begin
          mem_addr <= pc;
        end
      end

      if (capture) begin
        instr <= mem_rdata;
      end
    end
  end

  assign pc_plus4  = old_pc + 32'd4;
  assign dbg_state = state;

endmodule
